sc_stream_counter: RTL

Stochastic-to-binary converter placed directly downstream of the unipolar multiplier (AND) stage. It accepts a product bitstream as a sequence of LANES-bit beats over a valid/ready handshake. It counts the ones over a window of 2^N_LOG2 bits and then presents the count as a binary result on a valid/ready output port. Software divides the count by 2^N_LOG2 to get the probability estimate.

---
 rtl/sc_pkg.sv | 17 +
 rtl/sc_popcount.sv | 17 +
 rtl/sc_stream_counter.sv | 110 +++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing stream blocks.
package sc_pkg;

    localparam int unsigned DEFAULT_N_LOG2 = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } sc_state_e;

    // A window of 2^n_log2 bits can hold up to 2^n_log2 ones, so one extra bit.
    function automatic int unsigned sc_count_width(input int unsigned n_log2);
        return n_log2 + 1;
    endfunction

endpackage

// File: rtl/sc_popcount.sv
// Combinational population count of one LANES-bit beat.
module sc_popcount #(
    parameter int unsigned LANES = 1,
    localparam int unsigned CW   = $clog2(LANES) + 1
) (
    input  logic [LANES-1:0] bits,
    output logic [CW-1:0]    count_c
);

    always_comb begin
        count_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            count_c = count_c + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/sc_stream_counter.sv
// Counts ones over a 2^N_LOG2-bit window of a valid/ready bitstream and
// presents the total as a binary result on a valid/ready output.
module sc_stream_counter
    import sc_pkg::*;
#(
    parameter int unsigned N_LOG2 = DEFAULT_N_LOG2,
    parameter int unsigned LANES  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 auto_restart,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES-1:0]                     in_bits,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [sc_count_width(N_LOG2)-1:0]    out_count,
    output logic                                 busy
);

    localparam int unsigned CNT_W     = sc_count_width(N_LOG2);
    localparam int unsigned LANE_LOG2 = $clog2(LANES);
    localparam int unsigned PC_W      = LANE_LOG2 + 1;
    localparam int unsigned BEAT_W    = (N_LOG2 > LANE_LOG2) ? (N_LOG2 - LANE_LOG2) : 1;
    localparam int unsigned BEATS     = (2 ** N_LOG2) / LANES;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    sc_state_e          state_q, state_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               in_ready_q, out_valid_q, busy_q;
    logic [PC_W-1:0]    pc_c;
    logic [CNT_W-1:0]   sum_c;

    sc_popcount #(.LANES(LANES)) u_popcount (
        .bits    (in_bits),
        .count_c (pc_c)
    );

    // Next-state and datapath update; handshake outputs are decoded from state_d
    // so they come straight out of flops.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        count_d = count_q;
        sum_c   = acc_q + CNT_W'(pc_c);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    beat_d  = '0;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    if (beat_q == LAST_BEAT) begin
                        count_d = sum_c;
                        state_d = HOLD;
                    end else begin
                        acc_d  = sum_c;
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (auto_restart) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        beat_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            beat_q      <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            count_q     <= count_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == HOLD);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_count = count_q;
    assign busy      = busy_q;

endmodule
